// File: rtl/usart_pkg.sv
// Shared USART definitions: FSM state encoding, timing constants and the bit-period clamp.
package usart_pkg;

  localparam int MIN_CLOCKS_PER_BIT = 4;
  localparam int COUNTER_WIDTH      = 12;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } usart_state_e;

  function automatic logic [COUNTER_WIDTH-1:0] clamp_cpb(input logic [COUNTER_WIDTH-1:0] cpb);
    return (cpb < COUNTER_WIDTH'(MIN_CLOCKS_PER_BIT)) ? COUNTER_WIDTH'(MIN_CLOCKS_PER_BIT) : cpb;
  endfunction

endpackage

// File: rtl/usart_rx_sync.sv
// rx_pin synchronizer: SYNC_STAGES flops reset to idle-high, plus a registered
// falling-edge flag that is high in exactly the first cycle rx_s reads low.
module usart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic serial_clock,
  input  logic reset_n,
  input  logic rx_pin,
  output logic rx_s,
  output logic rx_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   fall_q, fall_d;

  // The edge is detected one stage early so the flag lines up with rx_s.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_pin};
    fall_d = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
  end

  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fall_q <= fall_d;
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = fall_q;

endmodule

// File: rtl/usart_rx_deframer.sv
// USART receive deframer: 8N1 (8E1 when USART_RX_PARITY_EN is defined) into a valid/ready byte stream.
// state  | meaning
// IDLE   | line idle, bit period latched, waiting for a falling edge
// START  | timing to mid start bit, rejecting glitches
// DATA   | sampling data bits LSB first every bit period
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit, committing or flagging the character
// BREAK  | stop bit was low, waiting for the line to return high
module usart_rx_deframer
  import usart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 serial_clock,
  input  logic                 reset_n,
  input  logic [11:0]          clocks_per_bit,
  input  logic                 rx_pin,
  output logic                 rts_pin,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 parity_error
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  logic                 rx_s, rx_fall;
  usart_state_e         state_q, state_d;
  cnt_t                 cnt_q, cnt_d, cpb_q, cpb_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, par_bad_q, par_bad_d;
  logic                 ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 bit_done, half_done, commit;
`ifdef USART_RX_PARITY_EN
  logic                 perr_q, perr_d;
`endif

  usart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .serial_clock(serial_clock),
    .reset_n     (reset_n),
    .rx_pin      (rx_pin),
    .rx_s        (rx_s),
    .rx_fall     (rx_fall)
  );

  assign bit_done  = (cnt_q == cpb_q - cnt_t'(1));
  assign half_done = (cnt_q == (cpb_q >> 1) - cnt_t'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + cnt_t'(1);
    cpb_d     = cpb_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    commit    = 1'b0;
`ifdef USART_RX_PARITY_EN
    perr_d    = 1'b0;
`endif
    case (state_q)
      // IDLE is only ever entered with the line high, so the edge flag marks a start.
      IDLE: begin
        cpb_d     = clamp_cpb(clocks_per_bit);
        cnt_d     = '0;
        par_bad_d = 1'b0;
        if (rx_fall) state_d = START;
      end
      START: if (half_done) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_done) begin
        cnt_d          = '0;
        shift_d[idx_q] = rx_s;
        idx_d          = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
`ifdef USART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef USART_RX_PARITY_EN
      PARITY: if (bit_done) begin
        cnt_d   = '0;
        state_d = STOP;
        if (rx_s != ^shift_q) begin
          par_bad_d = 1'b1;
          perr_d    = 1'b1;
        end
      end
`endif
      STOP: if (bit_done) begin
        cnt_d = '0;
        if (rx_s) begin
          commit  = !par_bad_q;
          state_d = IDLE;
        end else begin
          ferr_d  = !par_bad_q;
          state_d = BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (commit) begin
      if (!valid_q || out_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cpb_q     <= cnt_t'(MIN_CLOCKS_PER_BIT);
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_bad_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpb_q     <= cpb_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_bad_q <= par_bad_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef USART_RX_PARITY_EN
  always_ff @(posedge serial_clock or negedge reset_n) begin
    if (!reset_n) perr_q <= 1'b0;
    else          perr_q <= perr_d;
  end
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign rts_pin     = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_usart_rx_deframer.sv
// Self-checking bench for usart_rx_deframer: scenario tasks plus randomized frames
// checked against a byte-level model of the line protocol.
`timescale 1ns/1ps
module tb_usart_rx_deframer;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  logic        serial_clock = 1'b0;
  logic        reset_n;
  logic [11:0] clocks_per_bit;
  logic        rx_pin;
  logic        rts_pin;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        frame_error, overrun, parity_error;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] got_q[$];
  int n_ferr, n_ovr, n_perr, n_valid_cycles, n_rts_high, n_unstable, n_rts_mismatch;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
`ifdef USART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always #5 serial_clock = ~serial_clock;

  usart_rx_deframer #(.DATA_BITS(DATA_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .serial_clock  (serial_clock),
    .reset_n       (reset_n),
    .clocks_per_bit(clocks_per_bit),
    .rx_pin        (rx_pin),
    .rts_pin       (rts_pin),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .frame_error   (frame_error),
    .overrun       (overrun),
    .parity_error  (parity_error)
  );

  // Observe the stream away from the active edge.
  always @(negedge serial_clock) begin
    if (reset_n) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (frame_error === 1'b1) n_ferr++;
      if (overrun === 1'b1) n_ovr++;
      if (parity_error === 1'b1) n_perr++;
      if (out_valid === 1'b1) n_valid_cycles++;
      if (rts_pin === 1'b1) n_rts_high++;
      if (rts_pin !== out_valid) n_rts_mismatch++;
      if (prev_hold && out_data !== prev_data) n_unstable++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no end expected end of run");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge serial_clock);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_ferr = 0; n_ovr = 0; n_perr = 0; n_valid_cycles = 0;
    n_rts_high = 0; n_unstable = 0; n_rts_mismatch = 0;
  endtask

  // Drives one character; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb);
    rx_pin = 1'b0; tick(cpb);
    for (int i = 0; i < DATA_BITS; i++) begin rx_pin = b[i]; tick(cpb); end
`ifdef USART_RX_PARITY_EN
    rx_pin = (^b) ^ par_flip; tick(cpb);
`endif
    rx_pin = stop_bit; tick(cpb);
  endtask

  task automatic test_reset();
    tick(3);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", out_data); end
    tests_run++; if (rts_pin !== 1'b0) begin tests_failed++; $display("FAIL reset_rts: got %b expected 0", rts_pin); end
    tests_run++; if ({frame_error, overrun, parity_error} !== 3'b000) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 000", {frame_error, overrun, parity_error}); end
    reset_n = 1'b1;
    tick(5);
  endtask

  task automatic test_basic();
    int n, exp_lat;
    clocks_per_bit = 12'd32; out_ready = 1'b1; clear_mon(); tick(4);
    // Latency counted from the first edge that sees the low pin.
    exp_lat = (DATA_BITS + 1) * 32 + 32 / 2 + SYNC_STAGES + 1;
`ifdef USART_RX_PARITY_EN
    exp_lat += 32;
`endif
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, 32);
      begin
        while (n < 2000) begin
          @(posedge serial_clock); n++;
          @(negedge serial_clock);
          if (out_valid) break;
        end
      end
    join
    rx_pin = 1'b1; tick(64);
    tests_run++; if (n !== exp_lat) begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", n, exp_lat); end
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL basic_count: got %0d expected 1", got_q.size()); end
    tests_run++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %h expected a5", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    tests_run++; if (n_valid_cycles !== 1) begin tests_failed++; $display("FAIL basic_valid_width: got %0d expected 1", n_valid_cycles); end
    tests_run++; if (n_rts_high !== 1) begin tests_failed++; $display("FAIL basic_rts_width: got %0d expected 1", n_rts_high); end
    tests_run++; if (n_ferr + n_ovr + n_perr !== 0) begin tests_failed++; $display("FAIL basic_pulses: got %0d expected 0", n_ferr + n_ovr + n_perr); end
  endtask

  task automatic test_glitch();
    clocks_per_bit = 12'd32; out_ready = 1'b1; clear_mon(); tick(4);
    rx_pin = 1'b0; tick(10); rx_pin = 1'b1; tick(100);
    tests_run++; if (n_valid_cycles !== 0) begin tests_failed++; $display("FAIL glitch_valid: got %0d expected 0", n_valid_cycles); end
    tests_run++; if (n_ferr + n_ovr + n_perr !== 0) begin tests_failed++; $display("FAIL glitch_pulses: got %0d expected 0", n_ferr + n_ovr + n_perr); end
    send_frame(8'h5A, 1'b1, 32); rx_pin = 1'b1; tick(64);
    tests_run++; if (((got_q.size() == 1) ? got_q[0] : 8'hxx) !== 8'h5A) begin tests_failed++; $display("FAIL glitch_recover: got %0d bytes first %h expected 1 byte 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_frame_error();
    clocks_per_bit = 12'd16; out_ready = 1'b1; clear_mon(); tick(4);
    send_frame(8'h3C, 1'b0, 16);
    tick(100);
    rx_pin = 1'b1; tick(16);
    send_frame(8'h55, 1'b1, 16); rx_pin = 1'b1; tick(32);
    tests_run++; if (n_ferr !== 1) begin tests_failed++; $display("FAIL ferr_count: got %0d expected 1", n_ferr); end
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL ferr_bytes: got %0d expected 1", got_q.size()); end
    tests_run++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'h55) begin tests_failed++; $display("FAIL ferr_next: got %h expected 55", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_overrun();
    clocks_per_bit = 12'd16; out_ready = 1'b0; clear_mon(); tick(4);
    send_frame(8'h11, 1'b1, 16); rx_pin = 1'b1; tick(16);
    send_frame(8'h22, 1'b1, 16); rx_pin = 1'b1; tick(16);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid: got %b expected 1", out_valid); end
    tests_run++; if (out_data !== 8'h11) begin tests_failed++; $display("FAIL ovr_data: got %h expected 11", out_data); end
    tests_run++; if (n_ovr !== 1) begin tests_failed++; $display("FAIL ovr_count: got %0d expected 1", n_ovr); end
    tests_run++; if (rts_pin !== 1'b1) begin tests_failed++; $display("FAIL ovr_rts: got %b expected 1", rts_pin); end
    tests_run++; if (n_unstable !== 0) begin tests_failed++; $display("FAIL ovr_stable: got %0d changes expected 0", n_unstable); end
    out_ready = 1'b1; tick(1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_drain_valid: got %b expected 0", out_valid); end
    tests_run++; if (((got_q.size() == 1) ? got_q[0] : 8'hxx) !== 8'h11) begin tests_failed++; $display("FAIL ovr_drain_data: got %0d bytes first %h expected 1 byte 11", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_min_cpb();
    logic [7:0] bytes [4];
    int settings [2];
    settings = '{4, 1};
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'($urandom); bytes[3] = 8'($urandom);
    out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      clear_mon(); clocks_per_bit = 12'(settings[s]); tick(4);
      for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1, 4);
      rx_pin = 1'b1; tick(20);
      tests_run++; if (got_q.size() !== 4) begin tests_failed++; $display("FAIL min_cpb%0d_count: got %0d expected 4", settings[s], got_q.size()); end
      for (int i = 0; i < 4; i++) begin
        tests_run++; if (((i < got_q.size()) ? got_q[i] : 8'hxx) !== bytes[i]) begin tests_failed++; $display("FAIL min_cpb%0d_byte%0d: got %h expected %h", settings[s], i, (i < got_q.size()) ? got_q[i] : 8'hxx, bytes[i]); end
      end
      tests_run++; if (n_ferr + n_ovr + n_perr !== 0) begin tests_failed++; $display("FAIL min_cpb%0d_pulses: got %0d expected 0", settings[s], n_ferr + n_ovr + n_perr); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h81;
    clocks_per_bit = 12'd8; out_ready = 1'b0; clear_mon(); tick(2);
    send_frame(8'h99, 1'b1, 8); rx_pin = 1'b1; tick(8);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_hold: got %b expected 1", out_valid); end
    rx_pin = 1'b0; tick(8);
    for (int i = 0; i < 3; i++) begin rx_pin = b[i]; tick(8); end
    #2 reset_n = 1'b0; #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data: got %h expected 00", out_data); end
    tests_run++; if (rts_pin !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rts: got %b expected 0", rts_pin); end
    @(posedge serial_clock); #1;
    rx_pin = 1'b1; reset_n = 1'b1; out_ready = 1'b1; clear_mon(); tick(16);
    send_frame(8'h42, 1'b1, 8); rx_pin = 1'b1; tick(24);
    tests_run++; if (((got_q.size() == 1) ? got_q[0] : 8'hxx) !== 8'h42) begin tests_failed++; $display("FAIL rstmid_next: got %0d bytes first %h expected 1 byte 42", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    tests_run++; if (n_ferr + n_ovr + n_perr !== 0) begin tests_failed++; $display("FAIL rstmid_pulses: got %0d expected 0", n_ferr + n_ovr + n_perr); end
  endtask

  // Model: a good stop bit delivers the byte, a low stop bit costs one frame_error.
  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_ferr, raw, eff;
    logic [7:0] b;
    logic stop_ok;
    exp_ferr = 0;
    out_ready = 1'b1; clear_mon(); tick(2);
    for (int k = 0; k < 12; k++) begin
      raw = $urandom_range(0, 12);
      eff = (raw < 4) ? 4 : raw;
      clocks_per_bit = 12'(raw); tick(2);
      b = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      send_frame(b, stop_ok, eff);
      if (stop_ok) exp_q.push_back(b); else exp_ferr++;
      rx_pin = 1'b1; tick(eff + $urandom_range(0, 2 * eff));
    end
    tick(8);
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++; if (((i < got_q.size()) ? got_q[i] : 8'hxx) !== exp_q[i]) begin tests_failed++; $display("FAIL rand_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    tests_run++; if (n_ferr !== exp_ferr) begin tests_failed++; $display("FAIL rand_ferr: got %0d expected %0d", n_ferr, exp_ferr); end
    tests_run++; if (n_ovr + n_perr !== 0) begin tests_failed++; $display("FAIL rand_other_pulses: got %0d expected 0", n_ovr + n_perr); end
    tests_run++; if (n_rts_mismatch !== 0) begin tests_failed++; $display("FAIL rand_rts_track: got %0d mismatching cycles expected 0", n_rts_mismatch); end
  endtask

`ifdef USART_RX_PARITY_EN
  task automatic test_parity();
    clocks_per_bit = 12'd16; out_ready = 1'b1; clear_mon(); tick(4);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 16); rx_pin = 1'b1; tick(32);
    par_flip = 1'b0;
    tests_run++; if (n_perr !== 1) begin tests_failed++; $display("FAIL par_count: got %0d expected 1", n_perr); end
    tests_run++; if (n_valid_cycles !== 0) begin tests_failed++; $display("FAIL par_valid: got %0d expected 0", n_valid_cycles); end
    tests_run++; if (n_ferr + n_ovr !== 0) begin tests_failed++; $display("FAIL par_other_pulses: got %0d expected 0", n_ferr + n_ovr); end
    send_frame(8'h07, 1'b1, 16); rx_pin = 1'b1; tick(32);
    tests_run++; if (((got_q.size() == 1) ? got_q[0] : 8'hxx) !== 8'h07) begin tests_failed++; $display("FAIL par_good: got %0d bytes first %h expected 1 byte 07", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask
`endif

  initial begin
    reset_n = 1'b1; rx_pin = 1'b1; out_ready = 1'b1; clocks_per_bit = 12'd32;
    #2 reset_n = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_min_cpb();
    test_reset_mid();
    test_random();
`ifdef USART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
